frog_river: RTL and testbench
=============================

# frog_river

River-lane hazard tracker that consumes the per-frame log positions and directions produced by the log mover. It sits between the log mover and the frog motion logic. Each frame it decides whether the frog is standing on a log, drifting with it, slipping, or drowning. It outputs a registered carry displacement, the matched log index, and drown/dead status.

## Interface
- RIVER_Y_MIN, 72: top row (inclusive) of the river band.
- RIVER_Y_MAX, 167: bottom row (inclusive) of the river band.
- LANE_H, 24: lane height. The frog matches a log when frog_y == blogNy.
- LOG_HALF_W, 24: log half-width. blogNx is the log centre.
- LOG_STEP, 1: log displacement per frame, which becomes the magnitude of carry_dx.
- GRACE_FRAMES, 2: frames allowed in the river without a log before sinking.
- SINK_FRAMES, 30: length of the sink animation, in frames.
- X_MIN, 0 / X_MAX, 639: frog-centre limits while riding.
- frame_clk  input  1  frame clock. Reset is Reset, asynchronous, active-high; clock is frame_clk.
- Reset  input  1  asynchronous active-high reset.
- respawn  input  1  restarts the tracker: any state goes to SAFE.
- frog_x, frog_y  input  int  frog centre, signed.
- blog1x..blog9x, blog1y..blog9y  input  int  log centres, signed; x may be negative, down to -16.
- blog1dir..blog9dir  input  1  0 = moving right, 1 = moving left.
- state  output  3  current river_state_t.
- on_log  output  1  frog is riding a log.
- log_idx  output  4  matched log number 1..9; 0 = none.
- carry_dx  output  int  displacement the frog mover adds this frame: +LOG_STEP, -LOG_STEP, or 0.
- drown  output  1  one-frame pulse on entry to SINK.
- sink_cnt  output  5  sink animation frame index.
- dead  output  1  held high in DEAD.

## Operation
- Hit test for log N: frog_y == blogNy and blogNx-LOG_HALF_W <= frog_x < blogNx+LOG_HALF_W. All comparisons are signed 32-bit.
- If several logs hit, the lowest index wins.
- in_river = RIVER_Y_MIN <= frog_y <= RIVER_Y_MAX.
- prev_x holds the x of the matched log from the previous frame.
- Wrap detection applies in RIDING when the same index is still matched and |blogNx - prev_x| > 2*LOG_HALF_W.
- SAFE:
  - not in_river → stay.
  - hit → RIDING.
  - otherwise → SLIP with grace_cnt=1.
- RIDING:
  - not in_river → SAFE.
  - frog_x < X_MIN or frog_x > X_MAX → SINK.
  - wrap detected → SINK.
  - hit (any index) → RIDING; log_idx and prev_x update.
  - no hit → SLIP with grace_cnt=1.
- SLIP:
  - hit → RIDING.
  - not in_river → SAFE.
  - grace_cnt == GRACE_FRAMES → SINK.
  - otherwise grace_cnt increments.
- SINK:
  - carry_dx=0, on_log=0, log_idx=0.
  - sink_cnt increments each frame; at SINK_FRAMES-1 → DEAD.
- DEAD:
  - dead=1; outputs frozen.
  - respawn → SAFE.
- respawn in any state → SAFE next edge, with grace_cnt, sink_cnt and prev_x cleared. respawn has priority over every other transition.
- carry_dx in RIDING is +LOG_STEP if the matched dir is 0, else -LOG_STEP. It is 0 in every other state.

## Timing
- All outputs are registered and update on posedge frame_clk from inputs sampled at that edge. Latency is one frame.
- Reset values: state=SAFE, on_log=0, log_idx=0, carry_dx=0, drown=0, sink_cnt=0, dead=0, grace_cnt=0, prev_x=0.
- Reset asserted mid-SINK or mid-DEAD clears everything immediately, asynchronously.
- drown is high for exactly the one frame following the SINK entry edge. It is not re-asserted while in SINK or DEAD.
- The first SINK frame has sink_cnt=0. DEAD is entered SINK_FRAMES frames after SINK entry.
- Simultaneous conditions in RIDING use this priority: respawn > out-of-river > X limit > wrap > hit > no hit.

## Structure
- Package frog_pkg holds:
  - river_state_t enum {SAFE, RIDING, SLIP, SINK, DEAD}.
  - Shared constants LANE_H, LOG_HALF_W, and the river band limits, so the log mover and the renderer use the same values.
- Sub-module log_hit is a combinational single-log overlap test: inputs frog xy and log xy, output hit. It is instantiated 9 times.
- Top level contains the priority encoder, FSM, counters and prev_x register.

## Test plan
- Reset → all outputs 0, state=SAFE. Reset mid-SINK at sink_cnt=10 → sink_cnt=0, state=SAFE.
- frog (10,72), blog1 (0,72) dir 0 → next edge: RIDING, log_idx=1, on_log=1, carry_dx=+1. Same setup with dir=1 → carry_dx=-1.
- frog (300,96), no log at y=96 → SLIP, SLIP, then SINK with drown=1 for one frame. 30 frames later dead=1. respawn → SAFE with all outputs 0.
- frog (55,144), blog7x=48 and blog8x=60 both at y=144 → log_idx=7.
- Riding log1: blog1x goes 664 then -16 → SINK, drown=1.
- Riding with frog_x=640 → SINK. Frog moves to y=200 while riding → SAFE, carry_dx=0.

Source files
------------

// File: rtl/frog_pkg.sv
// Shared river constants and state type used by the log mover, renderer and hazard tracker.
package frog_pkg;

    typedef enum logic [2:0] {
        SAFE   = 3'd0,
        RIDING = 3'd1,
        SLIP   = 3'd2,
        SINK   = 3'd3,
        DEAD   = 3'd4
    } river_state_t;

    localparam int RIVER_Y_MIN  = 72;
    localparam int RIVER_Y_MAX  = 167;
    localparam int LANE_H       = 24;
    localparam int LOG_HALF_W   = 24;
    localparam int LOG_STEP     = 1;
    localparam int GRACE_FRAMES = 2;
    localparam int SINK_FRAMES  = 30;
    localparam int X_MIN        = 0;
    localparam int X_MAX        = 639;
    localparam int NUM_LOGS     = 9;

    function automatic logic inRiver(input int y);
        return (y >= RIVER_Y_MIN) && (y <= RIVER_Y_MAX);
    endfunction

    function automatic int absDiff(input int a, input int b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/frog_river_if.sv
// Bundle between the log mover / frog mover and the river hazard tracker.
interface frog_river_if;
    import frog_pkg::*;

    // Log N lives at index N so log numbers and array indices agree.
    logic                    respawn;
    int                      frog_x;
    int                      frog_y;
    int                      blog_x [1:NUM_LOGS];
    int                      blog_y [1:NUM_LOGS];
    logic [NUM_LOGS:1]       blog_dir;

    river_state_t            state;
    logic                    on_log;
    logic [3:0]              log_idx;
    int                      carry_dx;
    logic                    drown;
    logic [4:0]              sink_cnt;
    logic                    dead;

    modport master (
        output respawn, frog_x, frog_y, blog_x, blog_y, blog_dir,
        input  state, on_log, log_idx, carry_dx, drown, sink_cnt, dead
    );

    modport slave (
        input  respawn, frog_x, frog_y, blog_x, blog_y, blog_dir,
        output state, on_log, log_idx, carry_dx, drown, sink_cnt, dead
    );

endinterface

// File: rtl/frog_river_log_hit.sv
// Single-log overlap test: the frog stands on a log when it shares the lane row and lies within the log span.
module log_hit
    import frog_pkg::*;
(
    input  int   frog_x_i,
    input  int   frog_y_i,
    input  int   log_x_i,
    input  int   log_y_i,
    output logic hit_o
);

    // Span is half-open so adjacent logs never both claim the same pixel.
    always_comb begin
        hit_o = (frog_y_i == log_y_i)
             && (frog_x_i >= log_x_i - LOG_HALF_W)
             && (frog_x_i <  log_x_i + LOG_HALF_W);
    end

endmodule

// File: rtl/frog_river.sv
// River hazard tracker: decides each frame whether the frog rides, slips, sinks or is dead.
module frog_river
    import frog_pkg::*;
(
    input  logic         frame_clk,
    input  logic         Reset,
    frog_river_if.slave  bus
);

    logic [NUM_LOGS:1] hit;
    logic [3:0]        hitIdx;
    logic              anyHit;
    int                hitX;
    logic              hitDir;
    logic              frogInRiver;
    logic              xOut;
    logic              wrap;
    logic              goRide;
    logic              goSink;

    river_state_t      state_q,    state_d;
    logic              onLog_q,    onLog_d;
    logic [3:0]        logIdx_q,   logIdx_d;
    int                carryDx_q,  carryDx_d;
    logic              drown_q,    drown_d;
    logic [4:0]        sinkCnt_q,  sinkCnt_d;
    logic              dead_q,     dead_d;
    logic [1:0]        graceCnt_q, graceCnt_d;
    int                prevX_q,    prevX_d;

    for (genvar n = 1; n <= NUM_LOGS; n++) begin : g_hit
        log_hit u_log_hit (
            .frog_x_i (bus.frog_x),
            .frog_y_i (bus.frog_y),
            .log_x_i  (bus.blog_x[n]),
            .log_y_i  (bus.blog_y[n]),
            .hit_o    (hit[n])
        );
    end

    // Scan from the top index down so the lowest-numbered hitting log is the one left standing.
    always_comb begin
        hitIdx = 4'd0;
        anyHit = 1'b0;
        hitX   = 0;
        hitDir = 1'b0;
        for (int n = NUM_LOGS; n >= 1; n--) begin
            if (hit[n]) begin
                hitIdx = 4'(n);
                anyHit = 1'b1;
                hitX   = bus.blog_x[n];
                hitDir = bus.blog_dir[n];
            end
        end
    end

    always_comb begin
        frogInRiver = inRiver(bus.frog_y);
        xOut        = (bus.frog_x < X_MIN) || (bus.frog_x > X_MAX);
        // A log that teleported across the screen edge drags the frog under rather than along.
        wrap        = anyHit && (hitIdx == logIdx_q)
                   && (absDiff(hitX, prevX_q) > 2 * LOG_HALF_W);
    end

    always_comb begin
        state_d    = state_q;
        onLog_d    = 1'b0;
        logIdx_d   = 4'd0;
        carryDx_d  = 0;
        drown_d    = 1'b0;
        sinkCnt_d  = sinkCnt_q;
        dead_d     = 1'b0;
        graceCnt_d = graceCnt_q;
        prevX_d    = prevX_q;
        goRide     = 1'b0;
        goSink     = 1'b0;

        if (bus.respawn) begin
            state_d    = SAFE;
            sinkCnt_d  = 5'd0;
            graceCnt_d = 2'd0;
            prevX_d    = 0;
        end else begin
            unique case (state_q)
                SAFE: begin
                    if (frogInRiver) begin
                        if (anyHit) begin
                            goRide = 1'b1;
                        end else begin
                            state_d    = SLIP;
                            graceCnt_d = 2'd1;
                        end
                    end
                end
                RIDING: begin
                    if (!frogInRiver) begin
                        state_d = SAFE;
                    end else if (xOut || wrap) begin
                        goSink = 1'b1;
                    end else if (anyHit) begin
                        goRide = 1'b1;
                    end else begin
                        state_d    = SLIP;
                        graceCnt_d = 2'd1;
                    end
                end
                SLIP: begin
                    if (anyHit) begin
                        goRide = 1'b1;
                    end else if (!frogInRiver) begin
                        state_d = SAFE;
                    end else if (graceCnt_q == 2'(GRACE_FRAMES)) begin
                        goSink = 1'b1;
                    end else begin
                        graceCnt_d = graceCnt_q + 2'd1;
                    end
                end
                SINK: begin
                    if (sinkCnt_q == 5'(SINK_FRAMES - 1)) begin
                        state_d = DEAD;
                        dead_d  = 1'b1;
                    end else begin
                        sinkCnt_d = sinkCnt_q + 5'd1;
                    end
                end
                DEAD: begin
                    dead_d = 1'b1;
                end
                default: begin
                    state_d = SAFE;
                end
            endcase
        end

        if (goRide) begin
            state_d   = RIDING;
            onLog_d   = 1'b1;
            logIdx_d  = hitIdx;
            prevX_d   = hitX;
            carryDx_d = hitDir ? -LOG_STEP : LOG_STEP;
        end

        // drown is raised only on the edge that enters SINK, so it is a single-frame pulse.
        if (goSink) begin
            state_d   = SINK;
            sinkCnt_d = 5'd0;
            drown_d   = 1'b1;
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= SAFE;
            onLog_q    <= 1'b0;
            logIdx_q   <= 4'd0;
            carryDx_q  <= 0;
            drown_q    <= 1'b0;
            sinkCnt_q  <= 5'd0;
            dead_q     <= 1'b0;
            graceCnt_q <= 2'd0;
            prevX_q    <= 0;
        end else begin
            state_q    <= state_d;
            onLog_q    <= onLog_d;
            logIdx_q   <= logIdx_d;
            carryDx_q  <= carryDx_d;
            drown_q    <= drown_d;
            sinkCnt_q  <= sinkCnt_d;
            dead_q     <= dead_d;
            graceCnt_q <= graceCnt_d;
            prevX_q    <= prevX_d;
        end
    end

    assign bus.state    = state_q;
    assign bus.on_log   = onLog_q;
    assign bus.log_idx  = logIdx_q;
    assign bus.carry_dx = carryDx_q;
    assign bus.drown    = drown_q;
    assign bus.sink_cnt = sinkCnt_q;
    assign bus.dead     = dead_q;

endmodule

// File: tb/tb_frog_river.sv
// Bench for frog_river: directed scenarios plus random frames against a frame-level reference model.
module tb_frog_river;
    import frog_pkg::*;

    logic frame_clk = 1'b0;
    logic Reset;
    int   nCompared   = 0;
    int   nMismatched = 0;

    river_state_t mState;
    int           mGrace, mSink, mPrevX, mIdx, mCarry;
    bit           mOnLog, mDrown, mDead;

    frog_river_if bus ();

    frog_river dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus)
    );

    always #5 frame_clk = ~frame_clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic modelReset();
        mState = SAFE;
        mGrace = 0;  mSink = 0;  mPrevX = 0;  mIdx = 0;  mCarry = 0;
        mOnLog = 0;  mDrown = 0; mDead = 0;
    endtask

    // Reference: pick the next river situation first, then derive every output from it.
    task automatic modelStep();
        int           idx;
        bit           inRiv;
        river_state_t nxt;
        idx = 0;
        for (int n = 1; n <= NUM_LOGS; n++) begin
            if (idx == 0 && bus.frog_y == bus.blog_y[n] &&
                bus.frog_x >= bus.blog_x[n] - LOG_HALF_W && bus.frog_x < bus.blog_x[n] + LOG_HALF_W)
                idx = n;
        end
        inRiv = (bus.frog_y >= RIVER_Y_MIN) && (bus.frog_y <= RIVER_Y_MAX);
        nxt   = mState;
        if (bus.respawn) nxt = SAFE;
        else if (mState == SAFE) nxt = !inRiv ? SAFE : (idx != 0 ? RIDING : SLIP);
        else if (mState == RIDING) begin
            if (!inRiv) nxt = SAFE;
            else if (bus.frog_x < X_MIN || bus.frog_x > X_MAX) nxt = SINK;
            else if (idx != 0 && idx == mIdx &&
                     ((bus.blog_x[idx] - mPrevX) > 2 * LOG_HALF_W || (mPrevX - bus.blog_x[idx]) > 2 * LOG_HALF_W))
                nxt = SINK;
            else nxt = (idx != 0) ? RIDING : SLIP;
        end
        else if (mState == SLIP) begin
            if (idx != 0) nxt = RIDING;
            else if (!inRiv) nxt = SAFE;
            else nxt = (mGrace == GRACE_FRAMES) ? SINK : SLIP;
        end
        else if (mState == SINK) nxt = (mSink == SINK_FRAMES - 1) ? DEAD : SINK;

        if (bus.respawn) begin
            mGrace = 0; mSink = 0; mPrevX = 0;
        end else begin
            if (nxt == SLIP)   mGrace = (mState == SLIP) ? mGrace + 1 : 1;
            if (nxt == SINK)   mSink  = (mState == SINK) ? mSink + 1 : 0;
            if (nxt == RIDING) mPrevX = bus.blog_x[idx];
        end
        mDrown = (nxt == SINK) && (mState != SINK);
        mOnLog = (nxt == RIDING);
        mIdx   = (nxt == RIDING) ? idx : 0;
        mCarry = (nxt == RIDING) ? (bus.blog_dir[idx] ? -LOG_STEP : LOG_STEP) : 0;
        mDead  = (nxt == DEAD);
        mState = nxt;
    endtask

    task automatic applyStimulus();
        modelStep();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic clearLogs();
        for (int n = 1; n <= NUM_LOGS; n++) begin
            bus.blog_x[n]   = 0;
            bus.blog_y[n]   = -100;
            bus.blog_dir[n] = 1'b0;
        end
    endtask

    task automatic doRespawn();
        bus.respawn = 1'b1;
        applyStimulus();
        bus.respawn = 1'b0;
    endtask

    task automatic setFrog(input int x, input int y);
        bus.frog_x = x;
        bus.frog_y = y;
    endtask

    task automatic setLog(input int n, input int x, input int y, input logic dir);
        bus.blog_x[n]   = x;
        bus.blog_y[n]   = y;
        bus.blog_dir[n] = dir;
    endtask

    task automatic test_reset();
        Reset       = 1'b1;
        bus.respawn = 1'b0;
        clearLogs();
        setFrog(10, 300);
        modelReset();
        #12;
        nCompared++;
        if ({bus.state, bus.on_log, bus.log_idx, bus.drown, bus.sink_cnt, bus.dead} !== 15'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_outputs: got state=%0d on_log=%0b idx=%0d drown=%0b sink=%0d dead=%0b, required all 0",
                     bus.state, bus.on_log, bus.log_idx, bus.drown, bus.sink_cnt, bus.dead);
        end
        nCompared++;
        if (bus.carry_dx !== 0) begin
            nMismatched++;
            $display("[TB] FAIL reset_carry: got %0d required 0", bus.carry_dx);
        end
        @(negedge frame_clk);
        Reset = 1'b0;
    endtask

    task automatic test_ride();
        doRespawn();
        clearLogs();
        setFrog(10, 72);
        setLog(1, 0, 72, 1'b0);
        applyStimulus();
        nCompared++;
        if ({bus.state, bus.log_idx, bus.on_log} !== {RIDING, 4'd1, 1'b1} || bus.carry_dx !== 1) begin
            nMismatched++;
            $display("[TB] FAIL ride_right: got state=%0d idx=%0d on_log=%0b carry=%0d, required 1/1/1/+1",
                     bus.state, bus.log_idx, bus.on_log, bus.carry_dx);
        end
        doRespawn();
        bus.blog_dir[1] = 1'b1;
        applyStimulus();
        nCompared++;
        if (bus.state !== RIDING || bus.carry_dx !== -1) begin
            nMismatched++;
            $display("[TB] FAIL ride_left: got state=%0d carry=%0d, required 1/-1", bus.state, bus.carry_dx);
        end
    endtask

    task automatic test_slip_sink_dead();
        bit badPulse;
        doRespawn();
        clearLogs();
        setFrog(300, 96);
        applyStimulus();
        applyStimulus();
        nCompared++;
        if (bus.state !== SLIP || bus.drown !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL slip_grace: got state=%0d drown=%0b, required 2/0", bus.state, bus.drown);
        end
        applyStimulus();
        nCompared++;
        if ({bus.state, bus.drown, bus.sink_cnt, bus.on_log} !== {SINK, 1'b1, 5'd0, 1'b0} || bus.carry_dx !== 0) begin
            nMismatched++;
            $display("[TB] FAIL sink_entry: got state=%0d drown=%0b sink=%0d on_log=%0b carry=%0d, required 3/1/0/0/0",
                     bus.state, bus.drown, bus.sink_cnt, bus.on_log, bus.carry_dx);
        end
        badPulse = 1'b0;
        for (int i = 1; i <= SINK_FRAMES - 1; i++) begin
            applyStimulus();
            if (bus.drown !== 1'b0 || bus.dead !== 1'b0) badPulse = 1'b1;
        end
        nCompared++;
        if ({bus.state, bus.sink_cnt, badPulse} !== {SINK, 5'd29, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL sink_last: got state=%0d sink=%0d stray_pulse=%0b, required 3/29/0",
                     bus.state, bus.sink_cnt, badPulse);
        end
        applyStimulus();
        applyStimulus();
        nCompared++;
        if ({bus.state, bus.dead, bus.drown, bus.sink_cnt} !== {DEAD, 1'b1, 1'b0, 5'd29}) begin
            nMismatched++;
            $display("[TB] FAIL dead_hold: got state=%0d dead=%0b drown=%0b sink=%0d, required 4/1/0/29",
                     bus.state, bus.dead, bus.drown, bus.sink_cnt);
        end
        doRespawn();
        nCompared++;
        if ({bus.state, bus.dead, bus.drown, bus.sink_cnt, bus.on_log, bus.log_idx} !== 15'd0 || bus.carry_dx !== 0) begin
            nMismatched++;
            $display("[TB] FAIL respawn_clear: got state=%0d dead=%0b sink=%0d carry=%0d, required all 0",
                     bus.state, bus.dead, bus.sink_cnt, bus.carry_dx);
        end
    endtask

    task automatic test_priority_and_exits();
        clearLogs();
        setFrog(55, 144);
        setLog(7, 48, 144, 1'b1);
        setLog(8, 60, 144, 1'b0);
        applyStimulus();
        nCompared++;
        if (bus.log_idx !== 4'd7 || bus.carry_dx !== -1) begin
            nMismatched++;
            $display("[TB] FAIL lowest_index: got idx=%0d carry=%0d, required 7/-1", bus.log_idx, bus.carry_dx);
        end
        setFrog(55, 200);
        applyStimulus();
        nCompared++;
        if (bus.state !== SAFE || bus.carry_dx !== 0 || bus.on_log !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL leave_river: got state=%0d carry=%0d on_log=%0b, required 0/0/0",
                     bus.state, bus.carry_dx, bus.on_log);
        end
        clearLogs();
        setFrog(650, 72);
        setLog(1, 664, 72, 1'b0);
        applyStimulus();
        bus.blog_x[1] = -16;
        applyStimulus();
        nCompared++;
        if (bus.state !== SINK || bus.drown !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL edge_wrap_sink: got state=%0d drown=%0b, required 3/1", bus.state, bus.drown);
        end
        doRespawn();
        setFrog(20, 72);
        setLog(1, 40, 72, 1'b0);
        applyStimulus();
        setFrog(21, 72);
        bus.blog_x[1] = 41;
        applyStimulus();
        nCompared++;
        if (bus.state !== RIDING || bus.carry_dx !== 1) begin
            nMismatched++;
            $display("[TB] FAIL normal_drift: got state=%0d carry=%0d, required 1/+1", bus.state, bus.carry_dx);
        end
        setFrog(0, 72);
        bus.blog_x[1] = -16;
        applyStimulus();
        nCompared++;
        if (bus.state !== SINK || bus.drown !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL wrap_detect: got state=%0d drown=%0b, required 3/1", bus.state, bus.drown);
        end
        doRespawn();
        setFrog(620, 72);
        setLog(1, 630, 72, 1'b0);
        applyStimulus();
        setFrog(640, 72);
        bus.blog_x[1] = 631;
        applyStimulus();
        nCompared++;
        if (bus.state !== SINK) begin
            nMismatched++;
            $display("[TB] FAIL x_limit: got state=%0d required 3", bus.state);
        end
    endtask

    task automatic test_reset_mid_sink();
        int budget;
        doRespawn();
        clearLogs();
        setFrog(300, 120);
        budget = 0;
        while (!(bus.state == SINK && bus.sink_cnt == 5'd10) && budget < 60) begin
            applyStimulus();
            budget++;
        end
        nCompared++;
        if (budget >= 60) begin
            nMismatched++;
            $display("[TB] FAIL reach_sink10: got sink=%0d after %0d frames, required 10", bus.sink_cnt, budget);
        end
        #2;
        Reset = 1'b1;
        #1;
        nCompared++;
        if (bus.state !== SAFE || bus.sink_cnt !== 5'd0 || bus.drown !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL async_reset_sink: got state=%0d sink=%0d, required 0/0", bus.state, bus.sink_cnt);
        end
        modelReset();
        @(negedge frame_clk);
        Reset = 1'b0;
    endtask

    task automatic test_random();
        int ys [7] = '{50, 72, 96, 120, 144, 168, 200};
        int k;
        for (int n = 1; n <= NUM_LOGS; n++)
            setLog(n, int'($urandom_range(0, 680)) - 16, RIVER_Y_MIN + LANE_H * int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)));
        for (int f = 0; f < 800; f++) begin
            for (int n = 1; n <= NUM_LOGS; n++) begin
                bus.blog_x[n] += bus.blog_dir[n] ? -LOG_STEP : LOG_STEP;
                if (bus.blog_x[n] > 664) bus.blog_x[n] = -16;
                if (bus.blog_x[n] < -16) bus.blog_x[n] = 664;
                if ($urandom_range(0, 79) == 0) bus.blog_x[n] = int'($urandom_range(0, 680)) - 16;
            end
            bus.respawn = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 7) == 0) begin
                k = $urandom_range(1, NUM_LOGS);
                bus.frog_x = bus.blog_x[k] + int'($urandom_range(0, 60)) - 30;
                bus.frog_y = ($urandom_range(0, 2) == 0) ? ys[$urandom_range(0, 6)] : bus.blog_y[k];
            end else begin
                bus.frog_x += mCarry;
            end
            applyStimulus();
            nCompared++;
            if (bus.state !== mState) begin
                nMismatched++;
                $display("[TB] FAIL rnd_state f=%0d: got %0d required %0d", f, bus.state, mState);
            end
            nCompared++;
            if (bus.log_idx !== 4'(mIdx) || bus.on_log !== mOnLog) begin
                nMismatched++;
                $display("[TB] FAIL rnd_log f=%0d: got idx=%0d on=%0b required %0d/%0b", f, bus.log_idx, bus.on_log, mIdx, mOnLog);
            end
            nCompared++;
            if (bus.carry_dx !== mCarry) begin
                nMismatched++;
                $display("[TB] FAIL rnd_carry f=%0d: got %0d required %0d", f, bus.carry_dx, mCarry);
            end
            nCompared++;
            if (bus.drown !== mDrown || bus.dead !== mDead || bus.sink_cnt !== 5'(mSink)) begin
                nMismatched++;
                $display("[TB] FAIL rnd_sink f=%0d: got drown=%0b dead=%0b sink=%0d required %0b/%0b/%0d",
                         f, bus.drown, bus.dead, bus.sink_cnt, mDrown, mDead, mSink);
            end
        end
        bus.respawn = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ride();
        test_slip_sink_dead();
        test_priority_and_exits();
        test_reset_mid_sink();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
